// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK,
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } boot_state_e;

  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned CSUM_W    = 8;

  function automatic int unsigned lane_bits(input int unsigned bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/imem_boot_loader_packer.sv
// byte_word_packer: assembles little-endian bytes into DATA_WIDTH words and
// pulses word_ready for one cycle after the last byte of each word.
module byte_word_packer
  import boot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic                  word_ready,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = lane_bits(BYTES);

  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  ready_q, ready_d;

  always_comb begin
    lane_d  = lane_q;
    buf_d   = buf_q;
    word_d  = word_q;
    ready_d = 1'b0;
    if (byte_valid) begin
      buf_d[8*lane_q +: 8] = byte_in;
      if (lane_q == LANE_W'(BYTES - 1)) begin
        lane_d  = '0;
        word_d  = buf_d;
        ready_d = 1'b1;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q  <= '0;
      buf_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      ready_q <= ready_d;
    end
  end

  assign word_ready = ready_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory writes, then
// timed CPU reset release. Define IMEM_BOOT_CHECKSUM_EN for a trailing XOR byte.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam logic [32:0]  CAPACITY = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);
  localparam int unsigned  DLY_W    = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam int unsigned  REL_LAST = (RELEASE_DELAY > 1) ? RELEASE_DELAY - 2 : 0;
  // The triggering cycle counts as the first delay cycle, so a delay of one
  // releases straight from the triggering edge.
  localparam boot_state_e  REL_ENTRY = (RELEASE_DELAY > 1) ? ST_RELEASE : ST_RUN;

  boot_state_e           state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           words_q, words_d;
  logic [DLY_W-1:0]      delay_q, delay_d;
  logic [15:0]           n_hdr;
  logic                  pack_valid;
  logic                  word_ready;
  logic [DATA_WIDTH-1:0] word;
  logic                  last_word;
  logic                  data_full;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [CSUM_W-1:0]     csum_q, csum_d;
`endif

  byte_word_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_valid(pack_valid),
    .byte_in   (rx_data),
    .word_ready(word_ready),
    .word      (word)
  );

  assign last_word = ({1'b0, words_q} + 17'd1) == {1'b0, len_q};
  // A byte arriving while the final word is being written is not data.
  assign data_full = word_ready && last_word;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    words_d    = words_q;
    delay_d    = delay_q;
    n_hdr      = {rx_data, len_q[7:0]};
    pack_valid = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (word_ready) begin
      addr_d  = addr_q + ADDR_WIDTH'(1);
      words_d = words_q + 16'd1;
    end
    case (state_q)
      ST_LEN_LO: if (rx_valid) begin
        len_d[7:0] = rx_data;
        state_d    = ST_LEN_HI;
      end
      ST_LEN_HI: if (rx_valid) begin
        len_d   = n_hdr;
        delay_d = '0;
        if (n_hdr == 16'd0)                    state_d = REL_ENTRY;
        else if ({17'd0, n_hdr} > CAPACITY)    state_d = ST_ERROR;
        else                                   state_d = ST_DATA;
      end
      ST_DATA: begin
        pack_valid = rx_valid && !data_full;
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (rx_valid && data_full)
          state_d = (rx_data == csum_q) ? REL_ENTRY : ST_ERROR;
        else if (data_full)
          state_d = ST_CHK;
`else
        if (data_full) state_d = REL_ENTRY;
`endif
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHK: if (rx_valid) begin
        state_d = (rx_data == csum_q) ? REL_ENTRY : ST_ERROR;
      end
`endif
      ST_RELEASE: begin
        if (delay_q == DLY_W'(REL_LAST)) state_d = ST_RUN;
        else                             delay_d = delay_q + DLY_W'(1);
      end
      default: ;
    endcase
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (pack_valid) csum_d = csum_q ^ rx_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LEN_LO;
      len_q   <= '0;
      addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      words_q <= '0;
      delay_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      delay_q <= delay_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we       = word_ready;
  assign mem_addr     = addr_q;
  assign mem_wdata    = word;
  assign cpu_reset    = (state_q != ST_RUN);
  assign done         = (state_q == ST_RUN);
  assign error        = (state_q == ST_ERROR);
  assign busy         = state_q inside {ST_LEN_HI, ST_DATA, ST_CHK, ST_RELEASE};
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: the stimulus side queues expected
// writes, a negedge monitor pops and compares each mem_we pulse.
module tb_imem_boot_loader;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset, busy, done, error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .BASE_ADDR(0),
    .RELEASE_DELAY(RD)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rel_cyc = -1;
  logic prev_cpu_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e.addr));
        check("write_data", 64'(mem_wdata), 64'(e.data));
        check("write_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (reset) rel_cyc = -1;
    else if (prev_cpu_reset && !cpu_reset) rel_cyc = cyc;
    prev_cpu_reset = cpu_reset;
  end

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int k);
    int g;
    g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
    rx_valid = 1'b1;
    rx_data  = b;
    k = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends header + words (little-endian); stop_after >= 0 truncates the data
  // bytes. evt is the cycle from which the release delay is measured.
  task automatic load(input logic [31:0] w[$], input int n_hdr, input int gap,
                      input int stop_after, input logic [7:0] csum_flip, output int evt);
    int k;
    logic [7:0]  b;
    logic [7:0]  x;
    logic [15:0] n16;
    x   = 8'h00;
    n16 = 16'(n_hdr);
    send_byte(n16[7:0], gap, k);
    send_byte(n16[15:8], gap, k);
    evt = k;
    for (int i = 0; i < w.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        if (stop_after >= 0 && i * 4 + j >= stop_after) return;
        b = 8'(w[i] >> (8 * j));
        x = x ^ b;
        if (j == 3) exp_q.push_back('{addr: 8'(i), data: w[i], cyc: cyc + 1});
        send_byte(b, gap, k);
        if (j == 3) evt = k + 1;
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (n_hdr > 0 && n_hdr <= 256) begin
      send_byte(x ^ csum_flip, gap, k);
      evt = k;
    end
`endif
  endtask

  task automatic wait_end(input int budget);
    int b;
    b = budget;
    while (b > 0 && !(done || error)) begin
      @(posedge clk);
      #1;
      b--;
    end
    if (!(done || error)) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no done/error within %0d cycles, required done or error", budget);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_done(input int n, input int evt);
    wait_end(100);
    check("done", 64'(done), 64'd1);
    check("error_clear", 64'(error), 64'd0);
    check("cpu_reset_low", 64'(cpu_reset), 64'd0);
    check("busy_low", 64'(busy), 64'd0);
    check("words_loaded", 64'(words_loaded), 64'(n));
    check("release_cycle", 64'(rel_cyc), 64'(evt + RD));
    check("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic void rand_words(input int n, output logic [31:0] w[$]);
    w = {};
    for (int i = 0; i < n; i++) w.push_back($urandom);
  endfunction

  initial begin : stim
    logic [31:0] w[$];
    logic [31:0] w2[$];
    int evt;
    int k;
    int n;

    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;

    // Two-instruction program from the reference stream
    w = '{32'h0000_0013, 32'h0010_0093};
    load(w, 2, 0, -1, 8'h00, evt);
    check_done(2, evt);

    // Empty program
    do_reset();
    w = {};
    load(w, 0, 0, -1, 8'h00, evt);
    check_done(0, evt);

    // Oversized program: 257 words into 256-word memory
    do_reset();
    send_byte(8'h01, 0, k);
    check("busy_after_hdr", 64'(busy), 64'd1);
    send_byte(8'h01, 0, k);
    check("oversize_error", 64'(error), 64'd1);
    check("oversize_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0, k);
    repeat (3) begin @(posedge clk); #1; end
    check("oversize_cpu_reset", 64'(cpu_reset), 64'd1);
    check("oversize_done", 64'(done), 64'd0);
    check("oversize_words", 64'(words_loaded), 64'd0);

    // Reset part-way through the second word, then a fresh load
    do_reset();
    rand_words(2, w);
    load(w, 2, 0, 5, 8'h00, evt);
    repeat (3) begin @(posedge clk); #1; end
    check("partial_writes", 64'(exp_q.size()), 64'd0);
    do_reset();
    rand_words(2, w);
    load(w, 2, -1, -1, 8'h00, evt);
    check_done(2, evt);

    // Same program back-to-back and at one byte per 10 cycles
    rand_words(3, w2);
    do_reset();
    load(w2, 3, 0, -1, 8'h00, evt);
    check_done(3, evt);
    do_reset();
    load(w2, 3, 9, -1, 8'h00, evt);
    check_done(3, evt);

    // Random programs with random byte spacing
    for (int t = 0; t < 4; t++) begin
      n = int'($urandom_range(6, 1));
      rand_words(n, w);
      do_reset();
      load(w, n, -1, -1, 8'h00, evt);
      check_done(n, evt);
    end

    // Largest program that fits exactly
    rand_words(256, w);
    do_reset();
    load(w, 256, 0, -1, 8'h00, evt);
    check_done(256, evt);

`ifdef IMEM_BOOT_CHECKSUM_EN
    do_reset();
    w = '{32'h0000_0013};
    load(w, 1, 0, -1, 8'h00, evt);
    check_done(1, evt);

    do_reset();
    load(w, 1, 0, -1, 8'h01, evt);
    wait_end(100);
    check("csum_bad_error", 64'(error), 64'd1);
    check("csum_bad_cpu_reset", 64'(cpu_reset), 64'd1);
    check("csum_bad_done", 64'(done), 64'd0);
    check("csum_bad_words", 64'(words_loaded), 64'd1);
    check("csum_bad_writes", 64'(exp_q.size()), 64'd0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Hardware successor to the simulation-time program load and reset sequence used for the pipelined CPU.
- Receives a byte stream (UART receiver output) carrying a length header and program words.
- Assembles bytes into words and writes them into instruction memory at incrementing addresses.
- Holds the CPU in reset until the load completes, then releases it after a programmable delay.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, instruction memory word-address width.
- BASE_ADDR, 0, first word address written.
- RELEASE_DELAY, 4, cycles between the last memory write and CPU reset release; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- rx_data  in  8  received byte.
- mem_we  out  1  instruction memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_WIDTH  write word address.
- mem_wdata  out  DATA_WIDTH  write data.
- cpu_reset  out  1  reset to the CPU core; high until the load is released.
- busy  out  1  high from the first header byte accepted until DONE or ERROR.
- done  out  1  high once the CPU is released; sticky until reset.
- error  out  1  high on a rejected load; sticky until reset.
- words_loaded  out  16  count of words written so far.

Behaviour:
- Reset values (clk edge with reset=1):
  - State LEN_LO.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_reset=1, busy=0, done=0, error=0, words_loaded=0.
  - Byte counter and delay counter cleared.
- Stream format, all fields little-endian:
  - Length N, 16 bits: low byte, then high byte.
  - Then N words of DATA_WIDTH/8 bytes each.
- States:
  - LEN_LO: on rx_valid, latch N[7:0]; set busy=1; go to LEN_HI.
  - LEN_HI: on rx_valid, latch N[15:8].
    - If N=0: go to RELEASE.
    - If N > 2^ADDR_WIDTH − BASE_ADDR: go to ERROR.
    - Otherwise: go to DATA.
  - DATA: each rx_valid shifts the byte into the word buffer at byte lane = byte counter.
    - On the final byte of a word: next cycle mem_we=1, mem_wdata=assembled word, mem_addr=current address.
    - Address and words_loaded increment in the same cycle as the mem_we pulse.
    - Once words_loaded reaches N, go to RELEASE; with CHECKSUM_EN, go to CHK instead.
  - RELEASE: count RELEASE_DELAY cycles, then cpu_reset=0, done=1, busy=0; go to RUN.
  - RUN: all rx_valid ignored; no further writes.
  - ERROR: cpu_reset stays 1, error=1, busy=0; all input ignored until reset.
- Latency: mem_we asserts exactly 1 cycle after the rx_valid of a word's last byte.
- A byte arriving in the same cycle as a mem_we pulse is accepted normally. Back-to-back rx_valid on every cycle is supported.
- rx_valid=0 cycles never advance state. No timeout.
- Address wraps modulo 2^ADDR_WIDTH only arithmetically; the length check prevents a wrap ever being written.
- Reset asserted mid-load: state aborts next edge, no write issued that cycle, cpu_reset returns to 1.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - After the last data word, one extra byte is expected: the XOR of all data bytes (header excluded).
  - CHK state compares it. Match → RELEASE; mismatch → ERROR.
  - Already-written words remain in memory.
- Undefined:
  - No CHK state and no XOR accumulator; DATA goes directly to RELEASE.

Decomposition:
- Shared package boot_pkg:
  - State enum: LEN_LO, LEN_HI, DATA, CHK, RELEASE, RUN, ERROR.
  - Header byte count constant (2).
  - Checksum width constant (8).
- One natural sub-module: byte_word_packer, holding the byte-lane counter, shift buffer and word_ready pulse, parametrised by DATA_WIDTH.

Test Plan:
- Stream 02 00, then 13 00 00 00, then 93 00 10 00 →
  - Writes addr0=0x00000013 and addr1=0x00100093.
  - Each mem_we pulse comes 1 cycle after the word's last byte.
  - cpu_reset falls 4 cycles after the second write; done=1.
- Stream 00 00 → no mem_we; cpu_reset falls RELEASE_DELAY cycles after the second byte.
- ADDR_WIDTH=8, stream 01 01 (N=257) → error=1; cpu_reset stays 1; later bytes produce no writes.
- Reset pulsed after 5 of 8 data bytes, then a fresh full stream → only the fresh words written, starting at BASE_ADDR.
- rx_valid every cycle vs. one byte every 10 cycles → identical memory contents and words_loaded.
- IMEM_BOOT_CHECKSUM_EN defined:
  - One word 13 00 00 00 followed by checksum 13 → done=1.
  - Same word followed by checksum 12 → error=1, cpu_reset stays 1.
